// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// -----------------------------------------------------------------------------
// Multi-channel, runtime-programmable clock-enable generator for the low-rate
// RS232 logic. Each channel adds its increment to a fractional phase
// accumulator on every refclk edge. It emits a one-cycle tick on each
// accumulator wrap and a square wave taken from the accumulator MSB.
// A PLL-style lock handshake keeps all outputs quiet for LOCK_CYCLES edges
// after reset and after every accepted rate change.
//
// Ports:
//   refclk     - sole clock, rising edge
//   rst        - asynchronous, active-high reset
//   cfg_valid  - configuration request
//   cfg_ready  - configuration can be accepted (equal to locked)
//   cfg_ch     - target channel of the configuration beat
//   cfg_inc    - new phase increment for cfg_ch
//   ch_en      - per-channel run enable; a disabled channel is held at phase 0
//   tick       - per-channel one-cycle pulse on accumulator wrap
//   outclk     - per-channel accumulator MSB (roughly 50% duty square wave)
//   locked     - outputs are valid
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int          NUM_CH      = 2,
  parameter int          ACC_W       = 24,
  parameter int          LOCK_CYCLES = 16,
  parameter int unsigned DEFAULT_INC = 671089,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam logic [ACC_W-1:0] RESET_INC = DEFAULT_INC[ACC_W-1:0];
  localparam logic [15:0]      LOCK_LAST = 16'(LOCK_CYCLES - 1);

  typedef enum logic {
    LOCKING,
    LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       lock_cnt_q, lock_cnt_d;

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_d [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] outclk_q, outclk_d;

  logic              cfg_fire;
  logic              cfg_hit;
  logic              run;
  logic [ACC_W:0]    sum;

  // A beat is consumed whenever valid meets ready; only an in-range channel
  // number actually reprograms anything and forces a relock.
  assign cfg_fire = cfg_valid && cfg_ready;
  assign cfg_hit  = cfg_fire && (int'(cfg_ch) < NUM_CH);

  // State register and lock counter.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= LOCKING;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next-state logic. The counter value seen on an edge equals the number of
  // LOCKING edges already taken, so the LOCK_CYCLES-th edge is the one that
  // sees LOCK_LAST and moves to LOCKED.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      LOCKING: begin
        lock_cnt_d = lock_cnt_q + 16'd1;
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (cfg_hit) begin
          state_d    = LOCKING;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = LOCKING;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Output logic of the lock FSM.
  always_comb begin
    locked    = (state_q == LOCKED);
    cfg_ready = (state_q == LOCKED);
  end

  // Per-channel datapath. Accumulation only runs while locked; the edge that
  // accepts a configuration already behaves like LOCKING, so no channel
  // advances or ticks on it. The reprogrammed channel restarts from phase 0.
  always_comb begin
    run = (state_q == LOCKED) && !cfg_hit;
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c]    = acc_q[c];
      inc_d[c]    = inc_q[c];
      tick_d[c]   = 1'b0;
      outclk_d[c] = outclk_q[c];

      if (!ch_en[c]) begin
        acc_d[c]    = '0;
        outclk_d[c] = 1'b0;
      end else if (run) begin
        sum         = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
        acc_d[c]    = sum[ACC_W-1:0];
        tick_d[c]   = sum[ACC_W];
        outclk_d[c] = sum[ACC_W-1];
      end

      if (cfg_hit && (int'(cfg_ch) == c)) begin
        inc_d[c]    = cfg_inc;
        acc_d[c]    = '0;
        outclk_d[c] = 1'b0;
      end
    end
  end

  // Channel registers; reset restores the default rate on every channel.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        inc_q[c] <= RESET_INC;
      end
      tick_q   <= '0;
      outclk_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        inc_q[c] <= inc_d[c];
      end
      tick_q   <= tick_d;
      outclk_q <= outclk_d;
    end
  end

  assign tick   = tick_q;
  assign outclk = outclk_q;

endmodule
